fft_ctrl64: RTL and testbench
=============================

# fft_ctrl64

Sequencer for the radix-2 butterfly datapath of the 64-point FFT. On a start pulse it walks all 6 decimation-in-time stages of 32 butterflies each, one butterfly per cycle. For each butterfly it issues the operand read addresses and the twiddle index to the butterfly core, and it generates matching delayed write-back addresses for in-place storage. It sits between the top-level FFT control and the ping-free in-place data RAM, twiddle ROM and butterfly core.

## Interface
- `FFT_LOG`, 6, log2 of the FFT size. The block is verified at 6 only.
- `PIPE_LAT`, 2, cycles from `rd_en_o` to the matching `wr_en_o`: RAM read latency plus core register stages. Legal range is 1..4.
- `clk` input, 1 bit: the single clock. All logic is rising-edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start_i` input, 1 bit: starts a transform. Sampled only in IDLE.
- `busy_o` output, 1 bit: high from the cycle after `start_i` is accepted until `done_o`, inclusive.
- `done_o` output, 1 bit: one-cycle pulse when the last write-back has completed.
- `stage_o` output, 3 bits: current read stage, 0..5.
- `rd_en_o` output, 1 bit: operand read strobe.
- `rd_addr1_o` output, FFT_LOG bits: address of the upper butterfly operand.
- `rd_addr2_o` output, FFT_LOG bits: address of the lower butterfly operand.
- `wn_idx_o` output, FFT_LOG-1 bits: twiddle exponent k for W64^k. Valid with `rd_en_o`.
- `wr_en_o` output, 1 bit: write-back strobe.
- `wr_addr1_o` output, FFT_LOG bits: write-back address for core output 1.
- `wr_addr2_o` output, FFT_LOG bits: write-back address for core output 2.
- `hold_i` input, 1 bit: freeze request. Present only with `FFT_CTRL_HOLD_EN`.

## Operation
- FSM states are IDLE, RUN, GAP, FLUSH and DONE.
- IDLE → RUN when `start_i` is high. On entry, stage=0 and butterfly counter b=0.
- RUN issues one butterfly per cycle with `rd_en_o`=1, then increments b.
  - At b=31 with stage<5: go to GAP.
  - At b=31 with stage=5: go to FLUSH.
- GAP holds `rd_en_o`=0 for exactly PIPE_LAT cycles. This guarantees every write of stage s lands before the first read of stage s+1. Then stage increments, b is set to 0, and the FSM returns to RUN.
- FLUSH holds `rd_en_o`=0 for PIPE_LAT cycles, then goes to DONE.
- DONE drives `done_o`=1 for one cycle, then returns to IDLE.
- Address generation for stage s and butterfly b:
  - half = 2^s
  - pos = b mod half
  - grp = b >> s
  - `rd_addr1_o` = grp·2^(s+1) + pos
  - `rd_addr2_o` = `rd_addr1_o` + half
  - `wn_idx_o` = pos << (5−s)
- The data RAM holds input in bit-reversed order. Output is in natural order after stage 5.
- Write side is a PIPE_LAT-deep shift register carrying {valid, addr1, addr2}.
  - `wr_en_o` and `wr_addr*_o` are the tail of that shift register.
  - `wr_addr*_o` equals `rd_addr*_o` from PIPE_LAT cycles earlier.
- `start_i` is ignored while `busy_o`=1. A start is never queued.
- `stage_o` holds its value through GAP. It reads 5 in FLUSH and DONE.

## Timing
- Reset: in reset and immediately after it, every output is 0 (`busy_o`, `done_o`, `stage_o`, `rd_en_o`, all addresses, `wn_idx_o`, `wr_en_o`), the FSM is in IDLE, and the shift register is cleared.
- Reset asserted mid-transform:
  - `rd_en_o` and `wr_en_o` drop asynchronously.
  - Pending write-backs are discarded. No partial `done_o` is produced.
- Cycle numbering: cycle 1 is the first cycle with `rd_en_o`=1, i.e. the cycle after the `start_i` sampling edge.
- Stage s reads occupy cycles s·(32+PIPE_LAT)+1 through s·(32+PIPE_LAT)+32.
- The last write occurs in cycle 6·(32+PIPE_LAT).
- `done_o` is high in cycle 6·(32+PIPE_LAT)+1. This is cycle 205 for PIPE_LAT=2.
- `start_i` held high continuously: a new transform starts on the first edge back in IDLE. There is one idle cycle between `done_o` and the next cycle-1 read.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- `FFT_CTRL_HOLD_EN` defined:
  - The `hold_i` port exists.
  - While `hold_i`=1, the FSM, counters, GAP/FLUSH timers and write shift register all freeze.
  - `rd_en_o`=0 and `wr_en_o`=0 during hold. Addresses keep their values.
  - Hold in IDLE also blocks `start_i`.
  - Total latency grows by exactly the number of held cycles.
- `FFT_CTRL_HOLD_EN` undefined: there is no `hold_i` port and the block never stalls.

## Test plan
- Reset, then a `start_i` pulse with PIPE_LAT=2. Cycle 1 must show `rd_addr1_o`=0, `rd_addr2_o`=1, `wn_idx_o`=0, `stage_o`=0. Cycle 3 must show `wr_en_o`=1, `wr_addr1_o`=0, `wr_addr2_o`=1.
- Full-run address check for four butterflies:
  - s=1, b=3 → addresses (5, 7), wn 16
  - s=2, b=5 → addresses (9, 13), wn 8
  - s=5, b=31 → addresses (31, 63), wn 31
  - Over the whole transform: exactly 192 `rd_en_o` cycles, 192 `wr_en_o` cycles, and a `done_o` pulse only in cycle 205.
- Stage boundary: `rd_en_o`=0 in cycles 33–34. `wr_en_o` of stage-0 butterfly 31 occurs in cycle 34. The first stage-1 read is in cycle 35.
- Pulse `start_i` in cycle 50. No restart must occur, `done_o` must still be in cycle 205, and a pulse in cycle 206 must start a new run.
- Assert `rst` in cycle 100. All outputs must go to 0 immediately. After release there is no `wr_en_o` or `done_o` until a new start.
- With `FFT_CTRL_HOLD_EN`, hold `hold_i` high for cycles 10–14. Strobes must be low during hold, butterfly 9 must resume in cycle 15, and `done_o` must move to cycle 210.

Source files
------------

// File: rtl/fft_ctrl64.sv
// fft_ctrl64: address/strobe sequencer for a 64-point radix-2 DIT FFT.
// Walks FFT_LOG stages of 2^(FFT_LOG-1) butterflies, one butterfly per
// cycle. It issues the operand read addresses and the twiddle index, and
// replays the read addresses PIPE_LAT cycles later as in-place write-back
// addresses.
//
// Optional feature: define FFT_CTRL_HOLD_EN to add hold_i. While hold_i is
// high the whole sequencer freezes and both strobes are forced low.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start_i             start a transform (sampled in IDLE only)
//   busy_o, done_o      transform in progress / one-cycle completion pulse
//   stage_o             current read stage
//   rd_en_o             operand read strobe
//   rd_addr1_o/2_o      upper/lower butterfly operand addresses
//   wn_idx_o            twiddle exponent k of W^k, valid with rd_en_o
//   wr_en_o             write-back strobe
//   wr_addr1_o/2_o      write-back addresses for core outputs 1/2
//   hold_i              freeze request (FFT_CTRL_HOLD_EN builds only)
module fft_ctrl64 #(
  parameter int unsigned FFT_LOG  = 6,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2:0]         stage_o,
  output logic               rd_en_o,
  output logic [FFT_LOG-1:0] rd_addr1_o,
  output logic [FFT_LOG-1:0] rd_addr2_o,
  output logic [FFT_LOG-2:0] wn_idx_o,
  output logic               wr_en_o,
  output logic [FFT_LOG-1:0] wr_addr1_o,
  output logic [FFT_LOG-1:0] wr_addr2_o
`ifdef FFT_CTRL_HOLD_EN
  ,
  input  logic               hold_i
`endif
);

  localparam int unsigned AW = FFT_LOG;
  localparam int unsigned BW = FFT_LOG - 1;
  localparam int unsigned SW = 3;
  localparam int unsigned TW = 2;

  localparam logic [BW-1:0] B_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(FFT_LOG - 1);
  localparam logic [TW-1:0] T_LAST = TW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {IDLE, RUN, GAP, FLUSH, DONE} state_t;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
  } wb_t;

  state_t        state;
  logic [BW-1:0] bfly;
  logic [TW-1:0] timer;
  wb_t           pipe [PIPE_LAT];
  wb_t           ext  [PIPE_LAT];

  logic          hold_c;
  logic          issue_c;
  logic [SW-1:0] iss_s_c;
  logic [BW-1:0] iss_b_c;
  logic [AW-1:0] iss_a1_c;
  logic [AW-1:0] iss_a2_c;
  logic [BW-1:0] iss_wn_c;

`ifdef FFT_CTRL_HOLD_EN
  assign hold_c = hold_i;
`else
  assign hold_c = 1'b0;
`endif

  // Low s bits set: selects the position within a butterfly group.
  function automatic logic [AW-1:0] lo_mask(input logic [SW-1:0] s);
    return (AW'(1) << s) - AW'(1);
  endfunction

  // grp*2^(s+1) + pos: the group bits move up by one to open a gap of half.
  function automatic logic [AW-1:0] addr1_f(input logic [SW-1:0] s, input logic [BW-1:0] b);
    logic [AW-1:0] bx;
    logic [AW-1:0] m;
    bx = AW'(b);
    m  = lo_mask(s);
    return ((bx & ~m) << 1) | (bx & m);
  endfunction

  function automatic logic [AW-1:0] addr2_f(input logic [SW-1:0] s, input logic [BW-1:0] b);
    return addr1_f(s, b) | (AW'(1) << s);
  endfunction

  function automatic logic [BW-1:0] wn_f(input logic [SW-1:0] s, input logic [BW-1:0] b);
    return BW'((AW'(b) & lo_mask(s)) << (S_LAST - s));
  endfunction

  // Butterfly presented in the next cycle, and whether one is issued at all.
  always_comb begin
    iss_s_c = stage_o;
    iss_b_c = bfly + BW'(1);
    issue_c = 1'b0;
    unique case (state)
      IDLE: begin
        iss_s_c = '0;
        iss_b_c = '0;
        issue_c = start_i;
      end
      RUN:  issue_c = (bfly != B_LAST);
      GAP: begin
        iss_s_c = stage_o + SW'(1);
        iss_b_c = '0;
        issue_c = (timer == T_LAST);
      end
      default: issue_c = 1'b0;
    endcase
    iss_a1_c = addr1_f(iss_s_c, iss_b_c);
    iss_a2_c = addr2_f(iss_s_c, iss_b_c);
    iss_wn_c = wn_f(iss_s_c, iss_b_c);
  end

  // Write-back delay line input: the butterfly currently presented is valid in RUN.
  always_comb begin
    ext[0] = '{v: (state == RUN), a1: rd_addr1_o, a2: rd_addr2_o};
    for (int i = 1; i < int'(PIPE_LAT); i++) begin
      ext[i] = pipe[i-1];
    end
  end

  assign wr_addr1_o = pipe[PIPE_LAT-1].a1;
  assign wr_addr2_o = pipe[PIPE_LAT-1].a2;

  // Sequencer FSM, counters and write-back delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bfly       <= '0;
      timer      <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      stage_o    <= '0;
      rd_en_o    <= 1'b0;
      rd_addr1_o <= '0;
      rd_addr2_o <= '0;
      wn_idx_o   <= '0;
      wr_en_o    <= 1'b0;
      for (int i = 0; i < int'(PIPE_LAT); i++) begin
        pipe[i] <= '0;
      end
    end else if (hold_c) begin
      // Frozen: only the strobes are masked; all state keeps its value.
      rd_en_o <= 1'b0;
      wr_en_o <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      for (int i = 0; i < int'(PIPE_LAT); i++) begin
        pipe[i] <= ext[i];
      end
      wr_en_o <= ext[PIPE_LAT-1].v;
      rd_en_o <= 1'b0;
      done_o  <= 1'b0;

      if (issue_c) begin
        stage_o    <= iss_s_c;
        bfly       <= iss_b_c;
        rd_en_o    <= 1'b1;
        rd_addr1_o <= iss_a1_c;
        rd_addr2_o <= iss_a2_c;
        wn_idx_o   <= iss_wn_c;
      end

      unique case (state)
        IDLE: begin
          if (start_i) begin
            state  <= RUN;
            busy_o <= 1'b1;
          end
        end
        RUN: begin
          if (bfly == B_LAST) begin
            timer <= '0;
            state <= (stage_o == S_LAST) ? FLUSH : GAP;
          end
        end
        GAP: begin
          if (timer == T_LAST) begin
            state <= RUN;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        FLUSH: begin
          if (timer == T_LAST) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_ctrl64.sv
// tb_fft_ctrl64: self-checking bench for fft_ctrl64 (PIPE_LAT = 2).
// An address/timing model fills read, write and done queues at each start;
// every DUT strobe is popped and compared against them, alongside directed
// checks at the cycles of interest. Cycle 1 is the cycle after the edge
// that samples start_i.
module tb_fft_ctrl64;

  localparam int PL   = 2;
  localparam int SPAN = 32 + PL;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       busy_o;
  logic       done_o;
  logic [2:0] stage_o;
  logic       rd_en_o;
  logic [5:0] rd_addr1_o;
  logic [5:0] rd_addr2_o;
  logic [4:0] wn_idx_o;
  logic       wr_en_o;
  logic [5:0] wr_addr1_o;
  logic [5:0] wr_addr2_o;
`ifdef FFT_CTRL_HOLD_EN
  logic       hold_i;
`endif

  always #5 clk = ~clk;

  fft_ctrl64 #(.FFT_LOG(6), .PIPE_LAT(PL)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .stage_o    (stage_o),
    .rd_en_o    (rd_en_o),
    .rd_addr1_o (rd_addr1_o),
    .rd_addr2_o (rd_addr2_o),
    .wn_idx_o   (wn_idx_o),
    .wr_en_o    (wr_en_o),
    .wr_addr1_o (wr_addr1_o),
    .wr_addr2_o (wr_addr2_o)
`ifdef FFT_CTRL_HOLD_EN
    ,
    .hold_i     (hold_i)
`endif
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  st;
    logic [5:0]  a1;
    logic [5:0]  a2;
    logic [4:0]  wn;
  } rd_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [5:0]  a1;
    logic [5:0]  a2;
  } wr_t;

  rd_t rq[$];
  wr_t wq[$];
  int  dq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  logic [35:0] outs;
  assign outs = {busy_o, done_o, stage_o, rd_en_o, rd_addr1_o, rd_addr2_o,
                 wn_idx_o, wr_en_o, wr_addr1_o, wr_addr2_o};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cycles at or after the hold point slip by the number of held cycles.
  function automatic int hadj(input int c, input int base, input int hfrom, input int hlen);
    return (hlen > 0 && c >= base + hfrom) ? c + hlen : c;
  endfunction

  // Expected reads, write-backs and done pulse of one transform started at base.
  task automatic push_run(input int base, input int hfrom, input int hlen);
    rd_t r;
    wr_t w;
    int  half, pos, grp, c;
    for (int s = 0; s < 6; s++) begin
      for (int b = 0; b < 32; b++) begin
        half  = 1 << s;
        pos   = b % half;
        grp   = b >> s;
        c     = base + s * SPAN + b + 1;
        r.cyc = 32'(hadj(c, base, hfrom, hlen));
        r.st  = 3'(s);
        r.a1  = 6'(grp * 2 * half + pos);
        r.a2  = 6'(grp * 2 * half + pos + half);
        r.wn  = 5'(pos << (5 - s));
        w.cyc = 32'(hadj(c + PL, base, hfrom, hlen));
        w.a1  = r.a1;
        w.a2  = r.a2;
        rq.push_back(r);
        wq.push_back(w);
      end
    end
    dq.push_back(hadj(base + 6 * SPAN + 1, base, hfrom, hlen));
  endtask

  // Advance one cycle and score every strobe seen in it.
  task automatic tick();
    rd_t got_r;
    wr_t got_w;
    @(posedge clk);
    #1;
    cyc++;
    while (rq.size() > 0 && int'(rq[0].cyc) < cyc) begin
      chk("rd_missing_at", 64'(cyc), 64'(rq[0].cyc));
      void'(rq.pop_front());
    end
    while (wq.size() > 0 && int'(wq[0].cyc) < cyc) begin
      chk("wr_missing_at", 64'(cyc), 64'(wq[0].cyc));
      void'(wq.pop_front());
    end
    while (dq.size() > 0 && dq[0] < cyc) begin
      chk("done_missing_at", 64'(cyc), 64'(dq[0]));
      void'(dq.pop_front());
    end
    if (rd_en_o) begin
      rd_cnt++;
      if (rq.size() == 0) chk("rd_unexpected", 64'(rd_en_o), 64'(0));
      else begin
        got_r = '{cyc: 32'(cyc), st: stage_o, a1: rd_addr1_o, a2: rd_addr2_o, wn: wn_idx_o};
        chk("rd_cyc_st_a1_a2_wn", 64'(got_r), 64'(rq.pop_front()));
      end
    end
    if (wr_en_o) begin
      wr_cnt++;
      if (wq.size() == 0) chk("wr_unexpected", 64'(wr_en_o), 64'(0));
      else begin
        got_w = '{cyc: 32'(cyc), a1: wr_addr1_o, a2: wr_addr2_o};
        chk("wr_cyc_a1_a2", 64'(got_w), 64'(wq.pop_front()));
      end
    end
    if (done_o) begin
      done_cnt++;
      if (dq.size() == 0) chk("done_unexpected", 64'(done_o), 64'(0));
      else chk("done_cycle", 64'(cyc), 64'(dq.pop_front()));
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
`ifdef FFT_CTRL_HOLD_EN
    hold_i  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("outs_in_reset", 64'(outs), 64'(0));
    rst = 1'b0;
    tick();
    chk("outs_after_reset", 64'(outs), 64'(0));

    // Run 1: single start pulse, stage boundary, ignored restart.
    cyc = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    push_run(0, 0, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("c1_rd_en_busy", 64'({rd_en_o, busy_o}), 64'(2'b11));
    chk("c1_a1_a2_wn_st", 64'({rd_addr1_o, rd_addr2_o, wn_idx_o, stage_o}),
        64'({6'd0, 6'd1, 5'd0, 3'd0}));
    wait_to(3);
    chk("c3_wr", 64'({wr_en_o, wr_addr1_o, wr_addr2_o}), 64'({1'b1, 6'd0, 6'd1}));
    wait_to(33);
    chk("c33_gap_rd_st", 64'({rd_en_o, stage_o}), 64'({1'b0, 3'd0}));
    wait_to(34);
    chk("c34_gap_rd", 64'(rd_en_o), 64'(0));
    chk("c34_wr_b31", 64'({wr_en_o, wr_addr1_o, wr_addr2_o}), 64'({1'b1, 6'd62, 6'd63}));
    wait_to(35);
    chk("c35_stage1_first", 64'({rd_en_o, stage_o, rd_addr1_o, rd_addr2_o}),
        64'({1'b1, 3'd1, 6'd0, 6'd2}));
    wait_to(38);
    chk("s1b3", 64'({rd_addr1_o, rd_addr2_o, wn_idx_o}), 64'({6'd5, 6'd7, 5'd16}));
    wait_to(50);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_to(74);
    chk("s2b5", 64'({rd_addr1_o, rd_addr2_o, wn_idx_o}), 64'({6'd9, 6'd13, 5'd8}));
    wait_to(202);
    chk("s5b31", 64'({stage_o, rd_addr1_o, rd_addr2_o, wn_idx_o}),
        64'({3'd5, 6'd31, 6'd63, 5'd31}));
    wait_to(203);
    chk("flush_rd_st", 64'({rd_en_o, stage_o}), 64'({1'b0, 3'd5}));
    wait_to(205);
    chk("c205_done_busy", 64'({done_o, busy_o}), 64'(2'b11));
    wait_to(206);
    chk("c206_idle", 64'({done_o, busy_o}), 64'(2'b00));
    chk("run1_rd_count", 64'(rd_cnt), 64'(192));
    chk("run1_wr_count", 64'(wr_cnt), 64'(192));
    chk("run1_done_count", 64'(done_cnt), 64'(1));

    // Run 2: started by a pulse in cycle 206, reset in its cycle 100.
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    push_run(206, 0, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("c207_restart", 64'({rd_en_o, busy_o, rd_addr1_o}), 64'({1'b1, 1'b1, 6'd0}));
    wait_to(306);
    chk("pre_reset_strobes", 64'({rd_en_o, wr_en_o}), 64'(2'b11));
    rst = 1'b1;
    #1;
    chk("async_reset_outs", 64'(outs), 64'(0));
    rq.delete();
    wq.delete();
    dq.delete();
    tick();
    tick();
    rst = 1'b0;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    repeat (250) tick();
    chk("post_reset_quiet", 64'({rd_cnt[7:0], wr_cnt[7:0], done_cnt[7:0]}), 64'(0));
    chk("post_reset_outs", 64'(outs), 64'(0));

    // Run 3: start_i held high gives two back-to-back transforms.
    cyc = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    push_run(0, 0, 0);
    push_run(206, 0, 0);
    start_i = 1'b1;
    wait_to(206);
    chk("b2b_idle_gap", 64'({rd_en_o, busy_o, done_o}), 64'(3'b000));
    wait_to(207);
    start_i = 1'b0;
    chk("b2b_second_start", 64'({rd_en_o, stage_o}), 64'({1'b1, 3'd0}));
    wait_to(416);
    chk("b2b_rd_count", 64'(rd_cnt), 64'(384));
    chk("b2b_done_count", 64'(done_cnt), 64'(2));

`ifdef FFT_CTRL_HOLD_EN
    // Run 4: hold sampled at the edges that open cycles 10..14.
    cyc = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    push_run(0, 10, 5);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_to(9);
    hold_i = 1'b1;
    wait_to(10);
    chk("hold_strobes_low", 64'({rd_en_o, wr_en_o}), 64'(2'b00));
    wait_to(14);
    hold_i = 1'b0;
    wait_to(15);
    chk("hold_resume_b9", 64'({rd_en_o, rd_addr1_o, rd_addr2_o}), 64'({1'b1, 6'd18, 6'd19}));
    wait_to(212);
    chk("hold_done_count", 64'(done_cnt), 64'(1));
`endif

    chk("rq_drained", 64'(rq.size()), 64'(0));
    chk("wq_drained", 64'(wq.size()), 64'(0));
    chk("dq_drained", 64'(dq.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
